// File: rtl/interrupt_dispatch_controller.sv
// rtl/interrupt_dispatch_controller.sv - interrupt capture, vectoring, tail-chain and return sequencer
//
// Sits behind the interrupt priority encoder. A rising edge on interrupt_enable
// (seen only in IDLE) latches the prioritised handler pair and acknowledges the
// encoder. At the next instruction boundary the return PC is saved and the CPU
// is vectored to the first handler. Each rti either tail-chains to the second
// handler (when one was captured) or restores the saved PC.
//
// Ports:
//   clk                  rising-edge clock
//   rst_n                asynchronous active-low reset
//   interrupt_enable     level request from the priority encoder
//   interrupt_address    higher-priority handler address
//   interrupt_address_2  lower-priority handler address, 0 = none
//   pc_current           PC of the next instruction to execute
//   instr_boundary       CPU is between instructions (PC load is safe)
//   rti                  one-cycle pulse when a return-from-interrupt retires
//   interrupt_disable    one-cycle acknowledge pulse to the encoder
//   pc_load              one-cycle strobe: CPU loads pc_load_value
//   pc_load_value        target PC, held between strobes
//   in_service           high from first vector until the final return
//   overrun_count        saturating count of request edges dropped while busy

module interrupt_dispatch_controller #(
    parameter int addr_width    = 20,
    parameter int overrun_width = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     interrupt_enable,
    input  logic [addr_width-1:0]    interrupt_address,
    input  logic [addr_width-1:0]    interrupt_address_2,
    input  logic [addr_width-1:0]    pc_current,
    input  logic                     instr_boundary,
    input  logic                     rti,
    output logic                     interrupt_disable,
    output logic                     pc_load,
    output logic [addr_width-1:0]    pc_load_value,
    output logic                     in_service,
    output logic [overrun_width-1:0] overrun_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BOUNDARY,
        SERVICE1,
        SERVICE2
    } state_t;

    state_t                   state;
    state_t                   state_d;
    logic                     enable_q;
    logic [addr_width-1:0]    addr1_q;
    logic [addr_width-1:0]    addr2_q;
    logic [addr_width-1:0]    return_pc_q;

    logic [addr_width-1:0]    addr1_d;
    logic [addr_width-1:0]    addr2_d;
    logic [addr_width-1:0]    return_pc_d;
    logic                     interrupt_disable_d;
    logic                     pc_load_d;
    logic [addr_width-1:0]    pc_load_value_d;
    logic                     in_service_d;
    logic [overrun_width-1:0] overrun_count_d;

    logic                     request_edge;

    assign request_edge = interrupt_enable & ~enable_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            enable_q          <= 1'b0;
            addr1_q           <= '0;
            addr2_q           <= '0;
            return_pc_q       <= '0;
            interrupt_disable <= 1'b0;
            pc_load           <= 1'b0;
            pc_load_value     <= '0;
            in_service        <= 1'b0;
            overrun_count     <= '0;
        end else begin
            state             <= state_d;
            enable_q          <= interrupt_enable;
            addr1_q           <= addr1_d;
            addr2_q           <= addr2_d;
            return_pc_q       <= return_pc_d;
            interrupt_disable <= interrupt_disable_d;
            pc_load           <= pc_load_d;
            pc_load_value     <= pc_load_value_d;
            in_service        <= in_service_d;
            overrun_count     <= overrun_count_d;
        end
    end

    always_comb begin
        state_d             = state;
        addr1_d             = addr1_q;
        addr2_d             = addr2_q;
        return_pc_d         = return_pc_q;
        interrupt_disable_d = 1'b0;
        pc_load_d           = 1'b0;
        pc_load_value_d     = pc_load_value;
        in_service_d        = in_service;
        overrun_count_d     = overrun_count;

        case (state)
            IDLE: begin
                if (request_edge) begin
                    addr1_d             = interrupt_address;
                    addr2_d             = interrupt_address_2;
                    interrupt_disable_d = 1'b1;
                    state_d             = WAIT_BOUNDARY;
                end
            end
            WAIT_BOUNDARY: begin
                if (instr_boundary) begin
                    return_pc_d     = pc_current;
                    pc_load_d       = 1'b1;
                    pc_load_value_d = addr1_q;
                    in_service_d    = 1'b1;
                    state_d         = SERVICE1;
                end
            end
            SERVICE1: begin
                if (rti) begin
                    pc_load_d = 1'b1;
                    if (addr2_q != '0) begin
                        pc_load_value_d = addr2_q;
                        state_d         = SERVICE2;
                    end else begin
                        pc_load_value_d = return_pc_q;
                        in_service_d    = 1'b0;
                        state_d         = IDLE;
                    end
                end
            end
            SERVICE2: begin
                if (rti) begin
                    pc_load_d       = 1'b1;
                    pc_load_value_d = return_pc_q;
                    in_service_d    = 1'b0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Any edge outside IDLE is dropped, even on the cycle an rti sends us
        // back to IDLE; its addresses are never latched.
        if (request_edge && (state != IDLE) && (overrun_count != '1)) begin
            overrun_count_d = overrun_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_interrupt_dispatch_controller.sv
// tb/tb_interrupt_dispatch_controller.sv - scoreboard bench for interrupt_dispatch_controller

module tb_interrupt_dispatch_controller;

    localparam int AW = 20;
    localparam int OW = 4;

    logic          clk;
    logic          rst_n;
    logic          interrupt_enable;
    logic [AW-1:0] interrupt_address;
    logic [AW-1:0] interrupt_address_2;
    logic [AW-1:0] pc_current;
    logic          instr_boundary;
    logic          rti;
    logic          interrupt_disable;
    logic          pc_load;
    logic [AW-1:0] pc_load_value;
    logic          in_service;
    logic [OW-1:0] overrun_count;

    typedef struct {
        logic [AW-1:0] value;
        logic          svc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   disable_pulses = 0;
    logic prev_load = 1'b0;

    interrupt_dispatch_controller #(.addr_width(AW), .overrun_width(OW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .interrupt_enable    (interrupt_enable),
        .interrupt_address   (interrupt_address),
        .interrupt_address_2 (interrupt_address_2),
        .pc_current          (pc_current),
        .instr_boundary      (instr_boundary),
        .rti                 (rti),
        .interrupt_disable   (interrupt_disable),
        .pc_load             (pc_load),
        .pc_load_value       (pc_load_value),
        .in_service          (in_service),
        .overrun_count       (overrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard consumer: every pc_load strobe must match the next expected target.
    always @(negedge clk) begin
        if (rst_n && interrupt_disable) disable_pulses++;
        if (rst_n && pc_load) begin
            checks++;
            if (sb.size() == 0) begin
                assert (1'b0) else begin
                    errors++;
                    $error("FAIL unexpected_pc_load: observed=%h required=no load", pc_load_value);
                end
            end else begin
                exp_t e;
                e = sb.pop_front();
                assert (pc_load_value === e.value && in_service === e.svc) else begin
                    errors++;
                    $error("FAIL pc_load_target: observed=%h/%b required=%h/%b",
                           pc_load_value, in_service, e.value, e.svc);
                end
            end
            checks++;
            assert (!prev_load) else begin
                errors++;
                $error("FAIL pc_load_back_to_back: observed=1 required=0");
            end
        end
        prev_load = rst_n && pc_load;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h required=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [AW-1:0] v, input logic s);
        exp_t e;
        e.value = v;
        e.svc   = s;
        sb.push_back(e);
    endtask

    task automatic pulse_rti();
        rti = 1'b1;
        tick();
        rti = 1'b0;
    endtask

    task automatic request(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        interrupt_enable    = 1'b0;
        tick();
        interrupt_enable    = 1'b1;
        interrupt_address   = a1;
        interrupt_address_2 = a2;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        interrupt_enable = 1'b0;
        interrupt_address = '0;
        interrupt_address_2 = '0;
        pc_current = '0;
        instr_boundary = 1'b0;
        rti = 1'b0;
        tick();
        tick();
        check("reset_pc_load", {31'd0, pc_load}, 32'd0);
        check("reset_in_service", {31'd0, in_service}, 32'd0);
        check("reset_overrun", {28'd0, overrun_count}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single interrupt: edge, boundary already high, vector 2 cycles later.
        instr_boundary = 1'b1;
        pc_current     = 20'h00100;
        push(20'h01234, 1'b1);
        request(20'h01234, 20'h00000);
        check("t1_disable_pulse", {31'd0, interrupt_disable}, 32'd1);
        check("t1_no_early_load", {31'd0, pc_load}, 32'd0);
        tick();
        check("t1_vector_load", {31'd0, pc_load}, 32'd1);
        check("t1_vector_value", {12'd0, pc_load_value}, 32'h01234);
        check("t1_disable_once", {31'd0, interrupt_disable}, 32'd0);
        instr_boundary = 1'b0;
        pc_current     = 20'h0FFFF;
        tick();
        tick();
        check("t1_value_held", {12'd0, pc_load_value}, 32'h01234);
        push(20'h00100, 1'b0);
        pulse_rti();
        check("t1_return_value", {12'd0, pc_load_value}, 32'h00100);
        check("t1_in_service_fall", {31'd0, in_service}, 32'd0);
        tick();

        // Tail-chain: two handlers, in_service held across the chain.
        instr_boundary = 1'b1;
        pc_current     = 20'h00200;
        push(20'h0A000, 1'b1);
        push(20'h0B000, 1'b1);
        push(20'h00200, 1'b0);
        request(20'h0A000, 20'h0B000);
        tick();
        instr_boundary = 1'b0;
        tick();
        pulse_rti();
        check("t2_chain_in_service", {31'd0, in_service}, 32'd1);
        tick();
        check("t2_chain_in_service_hold", {31'd0, in_service}, 32'd1);
        pulse_rti();
        check("t2_final_in_service", {31'd0, in_service}, 32'd0);
        tick();

        // Delayed boundary: no load while waiting.
        instr_boundary = 1'b0;
        push(20'h0C000, 1'b1);
        push(20'h00300, 1'b0);
        request(20'h0C000, 20'h00000);
        begin
            int early;
            early = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (pc_load) early++;
            end
            check("t3_no_load_during_wait", early, 32'd0);
        end
        instr_boundary = 1'b1;
        pc_current     = 20'h00300;
        tick();
        check("t3_vector_after_boundary", {31'd0, pc_load}, 32'd1);
        instr_boundary = 1'b0;
        pc_current     = 20'h00000;
        tick();
        pulse_rti();
        check("t3_restore_value", {12'd0, pc_load_value}, 32'h00300);
        tick();
        check("t3_disable_count", disable_pulses, 32'd3);

        // Overrun: three edges in SERVICE1, then saturation in SERVICE2.
        instr_boundary = 1'b1;
        pc_current     = 20'h00500;
        push(20'h0D000, 1'b1);
        push(20'h0E000, 1'b1);
        request(20'h0D000, 20'h0E000);
        tick();
        instr_boundary = 1'b0;
        for (int i = 0; i < 3; i++) request(20'hFFFFF, 20'h11111);
        tick();
        check("t4_overrun_three", {28'd0, overrun_count}, 32'd3);
        check("t4_no_extra_disable", disable_pulses, 32'd4);
        pulse_rti();
        check("t4_addr2_unchanged", {12'd0, pc_load_value}, 32'h0E000);
        for (int i = 0; i < 20; i++) request(20'hFFFFF, 20'h22222);
        tick();
        check("t4_overrun_saturate", {28'd0, overrun_count}, 32'd15);
        check("t4_still_in_service", {31'd0, in_service}, 32'd1);

        // Async reset between edges during SERVICE2.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_reset_in_service", {31'd0, in_service}, 32'd0);
        check("t5_reset_overrun", {28'd0, overrun_count}, 32'd0);
        check("t5_reset_pc_load_value", {12'd0, pc_load_value}, 32'd0);
        check("t5_reset_disable", {31'd0, interrupt_disable}, 32'd0);
        sb.delete();
        interrupt_enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pulse_rti();
        check("t5_stray_rti_no_load", {31'd0, pc_load}, 32'd0);
        tick();

        // Zero first-handler address is still vectored to.
        instr_boundary = 1'b1;
        pc_current     = 20'h00400;
        push(20'h00000, 1'b1);
        push(20'h00400, 1'b0);
        request(20'h00000, 20'h00000);
        tick();
        check("t6_zero_vector_load", {31'd0, pc_load}, 32'd1);
        instr_boundary = 1'b0;
        tick();
        pulse_rti();
        check("t6_zero_restore", {12'd0, pc_load_value}, 32'h00400);
        tick();
        tick();

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interrupt_dispatch_controller.md
# interrupt_dispatch_controller

Sequential stage directly downstream of the interrupt priority encoder. Captures the encoder's prioritised address pair when `interrupt_enable` rises, acknowledges the encoder through `interrupt_disable`, and waits for an instruction boundary. It then saves the return PC and vectors the CPU to the higher-priority handler. When that handler returns, it tail-chains to the second handler if one exists, and otherwise restores the saved PC.

## Interface
Parameters:
- `addr_width`, 20, width of handler addresses and PC
- `overrun_width`, 4, width of the saturating overrun counter

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `interrupt_enable`  in  1  level request from the priority encoder
- `interrupt_address`  in  addr_width  higher-priority handler address
- `interrupt_address_2`  in  addr_width  lower-priority handler address; 0 means none
- `pc_current`  in  addr_width  PC of the next instruction to execute
- `instr_boundary`  in  1  CPU is between instructions; a PC load is safe this cycle
- `rti`  in  1  one-cycle pulse when a return-from-interrupt retires
- `interrupt_disable`  out  1  one-cycle acknowledge pulse to the encoder
- `pc_load`  out  1  one-cycle strobe: CPU loads `pc_load_value`
- `pc_load_value`  out  addr_width  target PC, valid while `pc_load`=1
- `in_service`  out  1  high from vectoring until the final return
- `overrun_count`  out  overrun_width  saturating count of requests dropped while busy

## Operation
- All outputs are registered.
- The block keeps `enable_q`, the previous-cycle value of `interrupt_enable`. A request edge is `interrupt_enable & ~enable_q`.
- Internal registers: `addr1_q`, `addr2_q`, `return_pc_q`, state.
- States: IDLE, WAIT_BOUNDARY, SERVICE1, SERVICE2.
- IDLE, request edge:
  - latch `addr1_q`/`addr2_q` from the inputs
  - pulse `interrupt_disable` next cycle
  - go to WAIT_BOUNDARY
- WAIT_BOUNDARY, `instr_boundary`=1:
  - `return_pc_q` <= `pc_current`
  - next cycle: `pc_load`=1, `pc_load_value`=`addr1_q`, `in_service`=1
  - go to SERVICE1
- SERVICE1, `rti`=1:
  - if `addr2_q`!=0: next cycle `pc_load`=1, `pc_load_value`=`addr2_q`; go to SERVICE2
  - else: next cycle `pc_load`=1, `pc_load_value`=`return_pc_q`, `in_service`=0; go to IDLE
- SERVICE2, `rti`=1: next cycle `pc_load`=1, `pc_load_value`=`return_pc_q`, `in_service`=0; go to IDLE.
- `rti` is ignored in IDLE and WAIT_BOUNDARY. `instr_boundary` is ignored outside WAIT_BOUNDARY.
- Overrun rules:
  - Only IDLE accepts a request edge.
  - An edge in any other state, including the cycle the FSM returns to IDLE, increments `overrun_count`.
  - `overrun_count` saturates at all-ones and clears only on reset.
  - The dropped request's addresses are discarded.
- Request edge and `rti` in the same SERVICE cycle: `rti` is processed and the edge is counted as an overrun.
- Width rules:
  - Address comparison against 0 uses the full `addr_width`.
  - No arithmetic is performed on addresses.
  - A handler address of 0 in `addr1_q` is still vectored to; only `addr2_q`=0 means "none".

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state=IDLE
  - `interrupt_disable`=0, `pc_load`=0, `pc_load_value`=0, `in_service`=0, `overrun_count`=0
  - `enable_q`=0, `addr1_q`=`addr2_q`=`return_pc_q`=0
- Reset release: the first active edge evaluates normally. If `interrupt_enable` is already high, that counts as a request edge.
- Reset mid-service: the handler context is abandoned, with no `pc_load` and no return.
- Latencies:
  - Request edge sampled at cycle N: `interrupt_disable`=1 in cycle N+1 only.
  - `instr_boundary` sampled at cycle M in WAIT_BOUNDARY: `pc_load` in M+1. `instr_boundary` high at N+1 gives the minimum request-to-vector latency of 2 cycles.
  - `rti` at cycle R: `pc_load` in R+1.
- `pc_load` is never high in two consecutive cycles.
- `pc_load_value` holds its last value when `pc_load`=0.
- `in_service` rises in the same cycle as the first vector `pc_load`. It falls in the same cycle as the restoring `pc_load`.

## Test plan
- Single interrupt, vector and return:
  - Stimulus: reset; `interrupt_enable` 0->1 with `interrupt_address`=0x01234 and `interrupt_address_2`=0; `instr_boundary`=1 with `pc_current`=0x00100; later `rti`.
  - Required response: `interrupt_disable` pulses once; `pc_load` with 0x01234 two cycles after the edge; after `rti`, `pc_load` with 0x00100, `in_service` falls, state IDLE.
- Tail-chain:
  - Stimulus: addresses 0x0A000 and 0x0B000; `pc_current`=0x00200; two `rti` pulses.
  - Required response: loads 0x0A000, then 0x0B000 after the first `rti`, then 0x00200 after the second; `in_service` stays high throughout.
- Delayed boundary:
  - Stimulus: hold `instr_boundary`=0 for 5 cycles after the request, then raise it with `pc_current`=0x00300.
  - Required response: no `pc_load` during the wait; vector in the cycle after the boundary; the return later restores 0x00300.
- Overrun:
  - Stimulus: toggle `interrupt_enable` 0->1 three times while in SERVICE1.
  - Required response: `overrun_count`=3, no extra `interrupt_disable` pulses, service addresses unchanged.
  - Stimulus: force 20 edges.
  - Required response: `overrun_count` saturates at 15.
- Async reset mid-service:
  - Stimulus: assert `rst_n`=0 between clock edges during SERVICE2.
  - Required response: all outputs 0 immediately; after release, a stray `rti` produces no `pc_load`.
